// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one MultiInputAdder between NUM_REQ requesters.
// Optional macro ADDER_SCHED_STATS_EN adds per-requester 32-bit accept counters (grant_cnt).

module MultiInputAdder #(
    parameter int NUM_INPUT = 7,
    parameter int WIDTH_IN  = 16,
    parameter int IS_SIGNED = 0,
    parameter int TRUNCATE  = 0,
    parameter int LATENCY   = 2,
    localparam int WIDTHOUT = (TRUNCATE != 0) ? WIDTH_IN : WIDTH_IN + $clog2(NUM_INPUT)
) (
    input  logic                                clk,
    input  logic                                ena,
    input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din,
    output logic [WIDTHOUT-1:0]                 dout
);
    // One spare bit so the accumulator never overflows before truncation.
    localparam int ACCW = WIDTH_IN + $clog2(NUM_INPUT) + 1;

    logic [ACCW-1:0]                   w_sum;
    logic [LATENCY-1:0][WIDTHOUT-1:0]  r_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (IS_SIGNED != 0) w_sum = w_sum + ACCW'($signed(din[i]));
            else                w_sum = w_sum + ACCW'(din[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            r_sum[0] <= w_sum[WIDTHOUT-1:0];
            for (int i = 1; i < LATENCY; i++) r_sum[i] <= r_sum[i-1];
        end
    end

    assign dout = r_sum[LATENCY-1];
endmodule

module adder_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_INPUT = 7,
    parameter int WIDTH_IN  = 16,
    parameter int IS_SIGNED = 0,
    parameter int TRUNCATE  = 0,
    parameter int ADDER_LAT = 2,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WIDTHOUT = (TRUNCATE != 0) ? WIDTH_IN : WIDTH_IN + $clog2(NUM_INPUT)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    input  logic [NUM_REQ-1:0][NUM_INPUT-1:0][WIDTH_IN-1:0]  req_din,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [IDW-1:0]                                   out_id,
    output logic [WIDTHOUT-1:0]                              out_data
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]                         grant_cnt
`endif
);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    logic                            w_adv;
    logic                            w_found;
    logic                            w_accept;
    logic [IDW-1:0]                  w_win;
    logic [IDW-1:0]                  r_ptr;
    logic [ADDER_LAT-1:0]            r_tag_vld;
    logic [ADDER_LAT-1:0][IDW-1:0]   r_tag_id;
    logic [WIDTHOUT-1:0]             w_sum;

    assign w_adv    = ~out_valid | out_ready;
    assign w_accept = w_found & w_adv & ~rst;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_win   = IDW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) req_ready[i] = w_accept && (w_win == IDW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst)           r_ptr <= '0;
        else if (w_accept) r_ptr <= (w_win == LAST) ? '0 : w_win + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else if (w_adv) begin
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= w_win;
            for (int i = 1; i < ADDER_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    MultiInputAdder #(
        .NUM_INPUT (NUM_INPUT),
        .WIDTH_IN  (WIDTH_IN),
        .IS_SIGNED (IS_SIGNED),
        .TRUNCATE  (TRUNCATE),
        .LATENCY   (ADDER_LAT)
    ) u_adder (
        .clk  (clk),
        .ena  (w_adv),
        .din  (req_din[w_win]),
        .dout (w_sum)
    );

    assign out_valid = r_tag_vld[ADDER_LAT-1];
    assign out_id    = r_tag_id[ADDER_LAT-1];
    assign out_data  = out_valid ? w_sum : '0;

`ifdef ADDER_SCHED_STATS_EN
    logic [NUM_REQ-1:0][31:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && req_valid[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: unsigned and signed instances share stimulus,
// a scoreboard checks every result's id and sum in accept order.

module tb_adder_rr_scheduler;
    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              req_valid;
    logic [3:0][6:0][15:0]   din;
    logic                    out_ready;

    logic [3:0]  rdy_u, rdy_s;
    logic        ov_u, ov_s;
    logic [1:0]  id_u, id_s;
    logic [18:0] data_u, data_s;
`ifdef ADDER_SCHED_STATS_EN
    logic [3:0][31:0] gcnt_u, gcnt_s;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [18:0] du;
        logic [18:0] ds;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.NUM_REQ(4), .NUM_INPUT(7), .WIDTH_IN(16), .IS_SIGNED(0), .TRUNCATE(0), .ADDER_LAT(2)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (rdy_u),
        .req_din   (din),
        .out_valid (ov_u),
        .out_ready (out_ready),
        .out_id    (id_u),
        .out_data  (data_u)
`ifdef ADDER_SCHED_STATS_EN
        ,
        .grant_cnt (gcnt_u)
`endif
    );

    adder_rr_scheduler #(.NUM_REQ(4), .NUM_INPUT(7), .WIDTH_IN(16), .IS_SIGNED(1), .TRUNCATE(0), .ADDER_LAT(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (rdy_s),
        .req_din   (din),
        .out_valid (ov_s),
        .out_ready (out_ready),
        .out_id    (id_s),
        .out_data  (data_s)
`ifdef ADDER_SCHED_STATS_EN
        ,
        .grant_cnt (gcnt_s)
`endif
    );

    function automatic logic [18:0] sum_u(input logic [6:0][15:0] v);
        logic [18:0] s = '0;
        for (int j = 0; j < 7; j++) s = s + 19'(v[j]);
        return s;
    endfunction

    function automatic logic [18:0] sum_s(input logic [6:0][15:0] v);
        logic [18:0] s = '0;
        for (int j = 0; j < 7; j++) s = s + 19'($signed(v[j]));
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            sb.delete();
        end else begin
            if (ov_u && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious_out", 64'(id_u), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 64'(id_u), 64'(e.id));
                    chk("sb_data_u", 64'(data_u), 64'(e.du));
                    chk("sb_data_s", 64'(data_s), 64'(e.ds));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && rdy_u[i]) begin
                    e.id = 2'(i);
                    e.du = sum_u(din[i]);
                    e.ds = sum_s(din[i]);
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_rdy;

        // reset state, with requests pending
        rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1; din = '0;
        @(negedge clk); @(negedge clk); #2;
        chk("rst_ready", 64'(rdy_u), 64'(0));
        chk("rst_valid", 64'(ov_u), 64'(0));
        chk("rst_id", 64'(id_u), 64'(0));
        chk("rst_data", 64'(data_u), 64'(0));

        // single requester
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0100;
        for (int r = 0; r < 4; r++) for (int j = 0; j < 7; j++) din[r][j] = 16'd1;
        #2 chk("single_ready", 64'(rdy_u), 64'(4'b0100));
        @(negedge clk); req_valid = 4'b0000;
        #2 chk("single_lat1_valid", 64'(ov_u), 64'(0));
        @(negedge clk); #2;
        chk("single_valid", 64'(ov_u), 64'(1));
        chk("single_id", 64'(id_u), 64'(2));
        chk("single_data", 64'(data_u), 64'(7));

        // fairness from a fresh pointer
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req_valid = 4'hF;
        for (int r = 0; r < 4; r++) for (int j = 0; j < 7; j++) din[r][j] = 16'($urandom);
        for (int k = 0; k < 12; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #2 chk("fair_ready", 64'(rdy_u), 64'(exp_rdy));
            @(negedge clk);
        end
        req_valid = 4'h0;
        repeat (3) @(negedge clk);

        // backpressure: pointer is back at 0
        for (int r = 0; r < 4; r++) for (int j = 0; j < 7; j++) din[r][j] = 16'($urandom);
        req_valid = 4'hF;
        #2 chk("bp_ready0", 64'(rdy_u), 64'(4'b0001));
        @(negedge clk);
        #2 chk("bp_ready1", 64'(rdy_u), 64'(4'b0010));
        @(negedge clk); out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("stall_valid", 64'(ov_u), 64'(1));
            chk("stall_id", 64'(id_u), 64'(0));
            chk("stall_data", 64'(data_u), 64'(sum_u(din[0])));
            chk("stall_ready", 64'(rdy_u), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #2 chk("bp_release_ready", 64'(rdy_u), 64'(4'b0100));
        @(negedge clk); req_valid = 4'h0;
        repeat (3) @(negedge clk);
        #2 chk("bp_drained", 64'(sb.size()), 64'(0));

        // extremes, pointer at 3 so requester 1 wins after wrap
        @(negedge clk);
        req_valid = 4'b0010;
        for (int j = 0; j < 7; j++) din[1][j] = 16'hFFFF;
        #2 chk("ext_ready", 64'(rdy_u), 64'(4'b0010));
        @(negedge clk); req_valid = 4'h0;
        @(negedge clk); #2;
        chk("ext_id", 64'(id_u), 64'(1));
        chk("ext_data_u", 64'(data_u), 64'(19'h6FFF9));
        chk("ext_data_s", 64'(data_s), 64'(19'h7FFF9));

        // reset with two results in flight
        @(negedge clk); req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; req_valid = 4'h0;
        @(negedge clk); rst = 1'b0; req_valid = 4'hF;
        #2;
        chk("rstmid_valid0", 64'(ov_u), 64'(0));
        chk("rstmid_ready", 64'(rdy_u), 64'(4'b0001));
        @(negedge clk); req_valid = 4'h0;
        #2 chk("rstmid_valid1", 64'(ov_u), 64'(0));
        @(negedge clk); #2;
        chk("rstmid_new_valid", 64'(ov_u), 64'(1));
        chk("rstmid_new_id", 64'(id_u), 64'(0));
        repeat (3) @(negedge clk);

`ifdef ADDER_SCHED_STATS_EN
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req_valid = 4'b0010;
        repeat (10) @(negedge clk);
        req_valid = 4'b1000;
        repeat (3) @(negedge clk);
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("gcnt0", 64'(gcnt_u[0]), 64'(0));
        chk("gcnt1", 64'(gcnt_u[1]), 64'(10));
        chk("gcnt2", 64'(gcnt_u[2]), 64'(0));
        chk("gcnt3", 64'(gcnt_u[3]), 64'(3));
        chk("gcnt_s1", 64'(gcnt_s[1]), 64'(10));
`endif

        #2 chk("sb_empty_end", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
